// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared definitions for the memory port arbiter and its sub-modules:
//   FSM state encoding, transaction owner encoding, counter width and
//   default timing constants.
package mem_port_arbiter_pkg;

    // Width of the latency and starvation counters; enough for 1..15.
    localparam int CNT_W          = 4;
    localparam int DEF_MEM_LAT    = 2;
    localparam int DEF_STARVE_MAX = 4;

    // FSM states, kept as plain constants so older code that compares
    // against raw 2-bit values keeps working.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_WAIT_IF = 2'd1;
    localparam state_t ST_WAIT_D  = 2'd2;

    // Which requester owns the outstanding transaction.
    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_D  = 1'b1
    } owner_t;

    // Waiting state that corresponds to a given owner.
    function automatic state_t wait_state(input owner_t owner);
        return (owner == OWNER_D) ? ST_WAIT_D : ST_WAIT_IF;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_starve.sv
// arb_starve_counter
//   Saturating counter of data grants that were given while fetch was also
//   waiting. Once it reaches LIMIT the arbiter hands the next contested slot
//   to fetch, which clears the count.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   inc        : count one contested data grant (saturates at LIMIT)
//   clr        : fetch was granted, start over (wins over inc)
//   at_limit   : count has reached LIMIT
module arb_starve_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int LIMIT = DEF_STARVE_MAX
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

    logic [CNT_W-1:0] count;

    // Clear has priority; increments stop once the limit is reached.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != LIMIT_C)) begin
            count <= count + 1'b1;
        end
    end

    assign at_limit = (count == LIMIT_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one fixed-latency memory port between the fetch stage and the
//   memory stage. One transaction is outstanding at a time. Data requests
//   win contested slots unless fetch has been passed over STARVE_MAX times
//   in a row.
// Ports:
//   clk, reset                    : clock, asynchronous active-high reset
//   if_req/if_addr                : fetch read request
//   if_gnt/if_rvalid/if_rdata     : fetch accept pulse, read data pulse, data
//   d_req/d_we/d_addr/d_wdata     : data load/store request
//   d_gnt/d_rvalid/d_rdata        : data accept pulse, completion pulse, data
//   mem_en/mem_we/mem_addr/mem_wdata : memory strobe and command (grant cycle)
//   mem_rdata                     : memory read data, MEM_LAT cycles later
//   busy                          : transaction outstanding
// Optional build macro ARB_PERF_CNT_EN adds 16-bit wrap-around counters
//   perf_if_gnt, perf_d_gnt and perf_conflict (IDLE cycles with both
//   requests asserted).
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DBITS      = 32,
    parameter int ABITS      = 32,
    parameter int MEM_LAT    = DEF_MEM_LAT,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_req,
    input  logic [ABITS-1:0] if_addr,
    output logic             if_gnt,
    output logic             if_rvalid,
    output logic [DBITS-1:0] if_rdata,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [ABITS-1:0] d_addr,
    input  logic [DBITS-1:0] d_wdata,
    output logic             d_gnt,
    output logic             d_rvalid,
    output logic [DBITS-1:0] d_rdata,
    output logic             mem_en,
    output logic             mem_we,
    output logic [ABITS-1:0] mem_addr,
    output logic [DBITS-1:0] mem_wdata,
    input  logic [DBITS-1:0] mem_rdata,
    output logic             busy
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [15:0]      perf_if_gnt,
    output logic [15:0]      perf_d_gnt,
    output logic [15:0]      perf_conflict
`endif
);

    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(MEM_LAT);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] lat_cnt;
    logic             idle;
    logic             starve_hit;
    logic             if_win;
    logic             d_win;
    logic             resp;

    // Grants are only handed out from IDLE and are masked while reset is
    // asserted so that every output reads 0 during reset.
    assign idle   = (state == ST_IDLE) && !reset;
    assign if_win = idle && if_req && (!d_req || starve_hit);
    assign d_win  = idle && d_req && (!if_req || !starve_hit);

    // lat_cnt holds MEM_LAT in the first waiting cycle and counts down, so
    // the value 1 marks the cycle grant+MEM_LAT.
    assign resp = (state != ST_IDLE) && (lat_cnt == ONE_C);

    assign if_gnt    = if_win;
    assign d_gnt     = d_win;
    assign if_rvalid = resp && (state == ST_WAIT_IF);
    assign d_rvalid  = resp && (state == ST_WAIT_D);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid ? mem_rdata : '0;

    // The memory command is only driven during the grant cycle.
    assign mem_en    = if_win || d_win;
    assign mem_we    = d_win && d_we;
    assign mem_addr  = d_win ? d_addr : (if_win ? if_addr : '0);
    assign mem_wdata = d_win ? d_wdata : '0;
    assign busy      = (state != ST_IDLE);

    // Next state: a grant moves to the owner's wait state, the response
    // cycle returns to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (mem_en) begin
                    state_nxt = wait_state(d_win ? OWNER_D : OWNER_IF);
                end
            end
            ST_WAIT_IF, ST_WAIT_D: begin
                if (resp) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register and latency countdown; reset drops any access in
    // flight so no response is ever produced for it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            lat_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (mem_en) begin
                lat_cnt <= LAT_C;
            end else if (lat_cnt != '0) begin
                lat_cnt <= lat_cnt - 1'b1;
            end
        end
    end

    arb_starve_counter #(
        .LIMIT(STARVE_MAX)
    ) u_starve (
        .clk     (clk),
        .reset   (reset),
        .inc     (d_win && if_req),
        .clr     (if_win),
        .at_limit(starve_hit)
    );

`ifdef ARB_PERF_CNT_EN
    // Free-running event counters; they wrap silently at 16 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_if_gnt   <= '0;
            perf_d_gnt    <= '0;
            perf_conflict <= '0;
        end else begin
            if (if_win) begin
                perf_if_gnt <= perf_if_gnt + 16'd1;
            end
            if (d_win) begin
                perf_d_gnt <= perf_d_gnt + 16'd1;
            end
            if (idle && if_req && d_req) begin
                perf_conflict <= perf_conflict + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. Instance A uses MEM_LAT=2 and
//   STARVE_MAX=4; instance B shares A's inputs and uses MEM_LAT=1 and
//   STARVE_MAX=1 to cover the short-latency and tight-starvation corners.
//   Honours ARB_PERF_CNT_EN when defined.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        ig;
        logic        dg;
        logic        irv;
        logic        drv;
        logic        men;
        logic        mwe;
        logic [31:0] maddr;
        logic [31:0] mwd;
        logic        busy;
        logic [31:0] ird;
        logic [31:0] drd;
    } outs_t;

    typedef struct packed {
        logic        ifr;
        logic [31:0] ifa;
        logic        dr;
        logic        dwe;
        logic [31:0] da;
        logic [31:0] dwd;
        logic [31:0] mrd;
    } ins_t;

    typedef struct packed {
        ins_t  in;
        outs_t exp;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] mem_rdata;

    logic        a_if_gnt, a_if_rvalid, a_d_gnt, a_d_rvalid, a_mem_en, a_mem_we, a_busy;
    logic [31:0] a_if_rdata, a_d_rdata, a_mem_addr, a_mem_wdata;
    logic        b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid, b_mem_en, b_mem_we, b_busy;
    logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata;
`ifdef ARB_PERF_CNT_EN
    logic [15:0] a_perf_if_gnt, a_perf_d_gnt, a_perf_conflict;
    logic [15:0] b_perf_if_gnt, b_perf_d_gnt, b_perf_conflict;
`endif

    int tests = 0;
    int fails = 0;
    vec_t vecs[16];

    mem_port_arbiter #(
        .DBITS(32), .ABITS(32), .MEM_LAT(2), .STARVE_MAX(4)
    ) dut_a (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(a_if_gnt),
        .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(mem_rdata), .busy(a_busy)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_if_gnt(a_perf_if_gnt), .perf_d_gnt(a_perf_d_gnt),
        .perf_conflict(a_perf_conflict)
`endif
    );

    mem_port_arbiter #(
        .DBITS(32), .ABITS(32), .MEM_LAT(1), .STARVE_MAX(1)
    ) dut_b (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(b_if_gnt),
        .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(mem_rdata), .busy(b_busy)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_if_gnt(b_perf_if_gnt), .perf_d_gnt(b_perf_d_gnt),
        .perf_conflict(b_perf_conflict)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something keeps the main sequence from finishing.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(
        input logic ifr, input logic [31:0] ifa, input logic dr, input logic dwe,
        input logic [31:0] da, input logic [31:0] dwd, input logic [31:0] mrd,
        input logic ig, input logic dg, input logic irv, input logic drv,
        input logic men, input logic mwe, input logic [31:0] maddr,
        input logic [31:0] mwd, input logic bsy, input logic [31:0] ird,
        input logic [31:0] drd);
        vec_t v;
        v.in  = '{ifr, ifa, dr, dwe, da, dwd, mrd};
        v.exp = '{ig, dg, irv, drv, men, mwe, maddr, mwd, bsy, ird, drd};
        return v;
    endfunction

    function automatic outs_t sampleA();
        return '{a_if_gnt, a_d_gnt, a_if_rvalid, a_d_rvalid, a_mem_en, a_mem_we,
                 a_mem_addr, a_mem_wdata, a_busy, a_if_rdata, a_d_rdata};
    endfunction

    function automatic outs_t sampleB();
        return '{b_if_gnt, b_d_gnt, b_if_rvalid, b_d_rvalid, b_mem_en, b_mem_we,
                 b_mem_addr, b_mem_wdata, b_busy, b_if_rdata, b_d_rdata};
    endfunction

    function automatic string fmt(input outs_t o);
        return $sformatf("ig=%b dg=%b irv=%b drv=%b en=%b we=%b addr=%h wd=%h busy=%b ird=%h drd=%h",
                         o.ig, o.dg, o.irv, o.drv, o.men, o.mwe, o.maddr, o.mwd,
                         o.busy, o.ird, o.drd);
    endfunction

    task automatic applyStimulus(input ins_t s);
        if_req    = s.ifr;
        if_addr   = s.ifa;
        d_req     = s.dr;
        d_we      = s.dwe;
        d_addr    = s.da;
        d_wdata   = s.dwd;
        mem_rdata = s.mrd;
    endtask

    task automatic checkOutput(input string name, input outs_t act, input outs_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got {%s} expected {%s}", name, fmt(act), fmt(exp));
        end
    endtask

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Hold reset for two cycles with idle inputs; returns just after the
    // edge at which reset is released.
    task automatic doReset();
        reset = 1'b1;
        applyStimulus('0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Hold both requests until the pattern of grants has been seen, then
    // check grant order, spacing and the response of every access.
    task automatic runBothHeld(input bit use_b, input int lat, input string pattern, input string tag);
        int    n       = pattern.len();
        int    grants  = 0;
        int    resps   = 0;
        int    cyc     = 0;
        int    last    = -1;
        int    due     = -1;
        int    men_cnt = 0;
        logic  due_if  = 1'b0;
        outs_t o;
        doReset();
        while ((grants < n || resps < grants) && cyc < 80) begin
            @(posedge clk);
            #1;
            if_req    = (grants < n);
            d_req     = (grants < n);
            if_addr   = 32'h300;
            d_addr    = 32'h80;
            d_we      = 1'b0;
            d_wdata   = '0;
            mem_rdata = 32'h1000 + 32'(cyc);
            @(negedge clk);
            o = use_b ? sampleB() : sampleA();
            if (cyc == due) begin
                checkVal($sformatf("%s_rvalid%0d", tag, resps), {30'd0, o.irv, o.drv},
                         due_if ? 32'd2 : 32'd1);
                checkVal($sformatf("%s_rdata%0d", tag, resps), due_if ? o.ird : o.drd, mem_rdata);
                resps++;
            end
            if (o.ig || o.dg) begin
                checkVal($sformatf("%s_grant%0d", tag, grants), {30'd0, o.ig, o.dg},
                         (pattern[grants] == "I") ? 32'd2 : 32'd1);
                if (last >= 0) begin
                    checkVal($sformatf("%s_spacing%0d", tag, grants), 32'(cyc - last), 32'(lat + 1));
                end
                last   = cyc;
                due    = cyc + lat;
                due_if = o.ig;
                grants++;
            end
            if (o.men) begin
                men_cnt++;
            end
            cyc++;
        end
        checkVal({tag, "_complete"}, {grants == n, resps == n}, 32'd3);
        checkVal({tag, "_mem_en_count"}, 32'(men_cnt), 32'(n));
        applyStimulus('0);
    endtask

    initial begin
        int drv_seen;

        // Cycle-by-cycle script from a fresh reset with MEM_LAT=2.
        //          ifr  ifa    dr dwe da     dwd            mrd             ig dg irv drv en we maddr  mwd            bsy ird             drd
        vecs[0]  = mk(1, 'h100, 0, 0, 0,     0,            0,              1, 0, 0, 0, 1, 0, 'h100, 0,            0, 0,             0);
        vecs[1]  = mk(0, 0,     1, 1, 'h40,  'hDEADBEEF,   0,              0, 0, 0, 0, 0, 0, 0,     0,            1, 0,             0);
        vecs[2]  = mk(0, 0,     1, 1, 'h40,  'hDEADBEEF,   'h11112222,     0, 0, 1, 0, 0, 0, 0,     0,            1, 'h11112222,    0);
        vecs[3]  = mk(0, 0,     1, 1, 'h40,  'hDEADBEEF,   0,              0, 1, 0, 0, 1, 1, 'h40,  'hDEADBEEF,   0, 0,             0);
        vecs[4]  = mk(0, 0,     0, 0, 0,     0,            0,              0, 0, 0, 0, 0, 0, 0,     0,            1, 0,             0);
        vecs[5]  = mk(0, 0,     0, 0, 0,     0,            0,              0, 0, 0, 1, 0, 0, 0,     0,            1, 0,             0);
        vecs[6]  = mk(0, 0,     1, 0, 'h44,  0,            0,              0, 1, 0, 0, 1, 0, 'h44,  0,            0, 0,             0);
        vecs[7]  = mk(1, 'h200, 0, 0, 0,     0,            0,              0, 0, 0, 0, 0, 0, 0,     0,            1, 0,             0);
        vecs[8]  = mk(1, 'h200, 0, 0, 0,     0,            'hA5A5A5A5,     0, 0, 0, 1, 0, 0, 0,     0,            1, 0,             'hA5A5A5A5);
        vecs[9]  = mk(1, 'h200, 0, 0, 0,     0,            0,              1, 0, 0, 0, 1, 0, 'h200, 0,            0, 0,             0);
        vecs[10] = mk(0, 0,     0, 0, 0,     0,            0,              0, 0, 0, 0, 0, 0, 0,     0,            1, 0,             0);
        vecs[11] = mk(0, 0,     0, 0, 0,     0,            'h0BADF00D,     0, 0, 1, 0, 0, 0, 0,     0,            1, 'h0BADF00D,    0);
        vecs[12] = mk(1, 'h300, 1, 0, 'h80,  0,            0,              0, 1, 0, 0, 1, 0, 'h80,  0,            0, 0,             0);
        vecs[13] = mk(1, 'h300, 0, 0, 0,     0,            0,              0, 0, 0, 0, 0, 0, 0,     0,            1, 0,             0);
        vecs[14] = mk(1, 'h300, 0, 0, 0,     0,            'h12345678,     0, 0, 0, 1, 0, 0, 0,     0,            1, 0,             'h12345678);
        vecs[15] = mk(1, 'h300, 0, 0, 0,     0,            0,              1, 0, 0, 0, 1, 0, 'h300, 0,            0, 0,             0);

        // Reset state, including requests raised while reset is held.
        reset = 1'b1;
        applyStimulus('0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_idle_a", sampleA(), '0);
        @(posedge clk);
        #1;
        if_req  = 1'b1;
        if_addr = 32'h100;
        d_req   = 1'b1;
        d_addr  = 32'h40;
        @(negedge clk);
        checkOutput("reset_req_masked_a", sampleA(), '0);
        checkOutput("reset_req_masked_b", sampleB(), '0);
`ifdef ARB_PERF_CNT_EN
        checkVal("reset_perf_a", {a_perf_if_gnt, a_perf_d_gnt} | {16'd0, a_perf_conflict}, 32'd0);
`endif
        @(posedge clk);
        #1;
        applyStimulus('0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            applyStimulus(vecs[i].in);
            @(negedge clk);
            checkOutput($sformatf("vec%0d", i), sampleA(), vecs[i].exp);
        end

        // Contested slots with the default starvation limit.
        runBothHeld(1'b0, 2, "DDDDIDDDDI", "both_lat2");
`ifdef ARB_PERF_CNT_EN
        checkVal("perf_d_gnt", {16'd0, a_perf_d_gnt}, 32'd8);
        checkVal("perf_if_gnt", {16'd0, a_perf_if_gnt}, 32'd2);
        checkVal("perf_conflict", {16'd0, a_perf_conflict}, 32'd10);
`endif

        // MEM_LAT=1 with STARVE_MAX=1: strict alternation, 2-cycle spacing.
        runBothHeld(1'b1, 1, "DIDIDI", "both_lat1");

        // Reset in the cycle after a data grant kills that access.
        doReset();
        drv_seen = 0;
        @(posedge clk);
        #1;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h90;
        @(negedge clk);
        checkVal("abort_dgnt", {31'd0, a_d_gnt}, 32'd1);
        @(posedge clk);
        #1;
        d_req = 1'b0;
        reset = 1'b1;
        mem_rdata = 32'h5A5A0000;
        @(negedge clk);
        checkOutput("abort_outputs_zero", sampleA(), '0);
        @(posedge clk);
        #1;
        @(negedge clk);
        if (a_d_rvalid) drv_seen++;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        if_req  = 1'b1;
        if_addr = 32'h400;
        @(negedge clk);
        checkVal("abort_fresh_grant", {29'd0, a_if_gnt, a_mem_en, a_d_gnt}, 32'd6);
        checkVal("abort_fresh_addr", a_mem_addr, 32'h400);
        if (a_d_rvalid) drv_seen++;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            if_req    = 1'b0;
            mem_rdata = 32'h77000000 + 32'(k);
            @(negedge clk);
            if (a_d_rvalid) drv_seen++;
            if (k == 2) begin
                checkVal("abort_fresh_rvalid", {31'd0, a_if_rvalid}, 32'd1);
                checkVal("abort_fresh_rdata", a_if_rdata, 32'h77000002);
            end
        end
        checkVal("abort_no_d_rvalid", 32'(drv_seen), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates the single shared memory port between the fetch stage (instruction reads) and the memory stage (data loads/stores).
- Serializes transactions: one outstanding at a time, fixed-latency memory.
- Data requests have fixed priority; a starvation guard guarantees fetch forward progress.
- Sits between the pipeline stages and the memory macro. Its grant/valid outputs feed the stage stall logic.

Parameters:
DBITS, 32, data width
ABITS, 32, address width
MEM_LAT, 2, cycles from grant (mem_en) to mem_rdata valid; legal range 1..15
STARVE_MAX, 4, consecutive data grants allowed while fetch waits; legal range 1..15

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
if_req  in  1  fetch read request; held with stable if_addr until if_gnt
if_addr  in  ABITS  fetch address
if_gnt  out  1  fetch request accepted (1-cycle pulse)
if_rvalid  out  1  if_rdata valid (1-cycle pulse)
if_rdata  out  DBITS  fetch read data
d_req  in  1  data request; held with stable d_we/d_addr/d_wdata until d_gnt
d_we  in  1  1=store, 0=load
d_addr  in  ABITS  data address
d_wdata  in  DBITS  store data
d_gnt  out  1  data request accepted (1-cycle pulse)
d_rvalid  out  1  load data valid, or store complete (1-cycle pulse)
d_rdata  out  DBITS  load data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ABITS  memory address
mem_wdata  out  DBITS  memory write data
mem_rdata  in  DBITS  memory read data, valid MEM_LAT cycles after mem_en
busy  out  1  transaction outstanding

Behaviour:
- Reset state:
  - All outputs 0.
  - FSM in IDLE; latency counter 0; starvation counter 0.
  - Reset asserted mid-transaction aborts it: no rvalid is ever produced for the aborted access.
- FSM states:
  - IDLE: grants are combinational from req inputs, in the same cycle.
  - WAIT_IF / WAIT_D: owner recorded; latency counter loaded with MEM_LAT at grant and decremented each cycle.
- Arbitration (IDLE only):
  - Only d_req: grant data.
  - Only if_req: grant fetch.
  - Both asserted: grant data, unless starve_cnt == STARVE_MAX, in which case grant fetch.
- Grant cycle:
  - mem_en=1.
  - mem_addr/mem_we/mem_wdata driven from the winner; for fetch, mem_we=0 and mem_wdata=0.
  - Exactly one of if_gnt/d_gnt asserted.
  - FSM moves to WAIT_x at the next edge.
  - Outside grant cycles, all mem_* outputs are 0.
- Response:
  - Occurs in cycle grant+MEM_LAT.
  - The owner's rvalid pulses; its rdata passes mem_rdata through combinationally.
  - d_rdata on a store is don't-care.
  - FSM returns to IDLE at the next edge.
  - Next grant is possible at grant+MEM_LAT+1, so peak throughput is 1 access per MEM_LAT+1 cycles.
- busy: 1 from the cycle after grant through the response cycle inclusive.
- Starvation counter:
  - Increments on a d_gnt cycle in which if_req=1; saturates at STARVE_MAX.
  - Clears on if_gnt.
  - Holds otherwise.
- Request handling:
  - Requests arriving while busy are not granted and not dropped; they wait until IDLE.
  - A requester deasserting req before gnt is legal; no access occurs.
- MEM_LAT=1: response occurs the cycle immediately after grant.

Optional Feature:
- Macro ARB_PERF_CNT_EN adds three 16-bit wrap-around output ports, all reset to 0:
  - perf_if_gnt: count of if_gnt
  - perf_d_gnt: count of d_gnt
  - perf_conflict: count of IDLE cycles with if_req&&d_req
- Without the macro, these ports and their registers are absent and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - FSM state enum (IDLE, WAIT_IF, WAIT_D)
  - Owner encoding
  - Latency/starvation counter width constant (4 bits)
  - Default MEM_LAT/STARVE_MAX constants
- One natural sub-module, arb_starve_counter: saturating counter with inc/clr/limit-reached output.

Test Plan:
- MEM_LAT=2, reset held, then released: all outputs 0; if_req=1, if_addr=0x100 at cycle 0 -> if_gnt=mem_en=1 at cycle 0 with mem_addr=0x100; if_rvalid=1 at cycle 2 with if_rdata=mem_rdata; busy high in cycles 1-2.
- Store: d_req=1, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF -> mem_we=1 with those values in the grant cycle; d_rvalid pulse 2 cycles later; if_gnt stays 0.
- Simultaneous: if_req and d_req held continuously -> grant sequence D,D,D,D,IF,D,D,D,D,IF; grants spaced 3 cycles apart.
- Request while busy: d_req raised 1 cycle after an if_gnt -> d_gnt occurs at the first IDLE cycle (grant+3); no lost or duplicate mem_en.
- Reset asserted in the cycle after a d_gnt -> no d_rvalid ever; all outputs 0; a fresh if_req after release is granted immediately.
- ARB_PERF_CNT_EN defined, simultaneous-requests scenario for 10 grants -> perf_d_gnt=8, perf_if_gnt=2, perf_conflict=10.
